// File: rtl/filt_capture_pkg.sv
// Shared types and helpers for the filter-output capture block.
package filt_capture_pkg;

   localparam int DATA_W_DEF = 18;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      DRAIN
   } cap_state_t;

   // Magnitude of a signed sample, saturating the most negative code to the
   // largest positive one so the result always fits in the sample width.
   function automatic logic [DATA_W_DEF-1:0] abs_sat(input logic signed [DATA_W_DEF-1:0] y);
      logic [DATA_W_DEF-1:0] mag;
      if (y == {1'b1, {(DATA_W_DEF-1){1'b0}}})
         mag = {1'b0, {(DATA_W_DEF-1){1'b1}}};
      else if (y[DATA_W_DEF-1])
         mag = -y;
      else
         mag = y;
      return mag;
   endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read with one
// cycle of latency. The array itself is never reset.
module capture_ram
   import filt_capture_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int DATA_W = DATA_W_DEF,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: one sample per enabled cycle
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Read port: data appears the cycle after the read is issued
   always_ff @(posedge clk) begin
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/filt_capture.sv
// Capture sink for the filter output stream. Arms on request, triggers on a
// magnitude threshold crossing or a forced trigger, records DEPTH samples and
// drains them over a valid/ready stream.
// Optional peak-magnitude statistics: define FILT_CAPTURE_STATS_EN.
module filt_capture
   import filt_capture_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 256
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic signed [DATA_W-1:0] y,
   input  logic                     arm,
   input  logic                     abort,
   input  logic                     trig_force,
   input  logic        [DATA_W-2:0] thresh,
   output logic                     busy,
   output logic signed [DATA_W-1:0] dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     dout_last
`ifdef FILT_CAPTURE_STATS_EN
   ,
   output logic        [DATA_W-1:0] peak
`endif
);

   localparam int AW = $clog2(DEPTH);

   cap_state_t state;
   cap_state_t state_next;

   logic signed [DATA_W-1:0] y_q;
   logic signed [DATA_W:0]   y_ext;
   logic signed [DATA_W:0]   thr_pos;
   logic signed [DATA_W:0]   thr_neg;
   logic                     trigger;
   logic                     trigger_fire;

   logic                     wr_en;
   logic [AW-1:0]            waddr;

   logic                     rd_en;
   logic [AW-1:0]            raddr;
   logic                     rd_done;
   logic                     rd_inflight;
   logic                     rd_last_q;
   logic [DATA_W-1:0]        rd_data;

   logic [DATA_W-1:0]        skid_data;
   logic                     skid_last;
   logic                     skid_valid;
   logic                     pop;
   logic [2:0]               occupancy;

   // Threshold compare in one extra bit so the most negative sample and the
   // negated threshold are both representable.
   assign y_ext   = {y_q[DATA_W-1], y_q};
   assign thr_pos = {2'b00, thresh};
   assign thr_neg = -thr_pos;
   assign trigger = trig_force || (y_ext >= thr_pos) || (y_ext <= thr_neg);

   assign pop  = dout_valid && dout_ready;
   assign busy = (state != IDLE);

   // Register the incoming sample; every decision looks at this copy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         y_q <= '0;
      else
         y_q <= y;
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state and write control; abort overrides everything else
   always_comb begin
      state_next   = state;
      wr_en        = 1'b0;
      trigger_fire = 1'b0;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (arm)
                  state_next = ARMED;
            end
            ARMED: begin
               if (trigger) begin
                  trigger_fire = 1'b1;
                  wr_en        = 1'b1;
                  state_next   = CAPTURE;
               end
            end
            CAPTURE: begin
               wr_en = 1'b1;
               if (waddr == AW'(DEPTH - 1))
                  state_next = DRAIN;
            end
            DRAIN: begin
               if (pop && dout_last)
                  state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Write address advances with each stored sample and rests at 0 otherwise,
   // so the triggering sample always lands at address 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         waddr <= '0;
      else if (wr_en)
         waddr <= waddr + 1'b1;
      else
         waddr <= '0;
   end

   // Issue a read only while the output register, skid register and the read
   // in flight together leave room for the returning data
   always_comb begin
      occupancy = 3'(dout_valid) + 3'(skid_valid) + 3'(rd_inflight) - 3'(pop);
      rd_en     = (state == DRAIN) && !abort && !rd_done && (occupancy < 3'd2);
   end

   // Read address sequencing and tracking of the read in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         raddr       <= '0;
         rd_done     <= 1'b0;
         rd_inflight <= 1'b0;
         rd_last_q   <= 1'b0;
      end else if ((state != DRAIN) || abort) begin
         raddr       <= '0;
         rd_done     <= 1'b0;
         rd_inflight <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         rd_inflight <= rd_en;
         if (rd_en) begin
            rd_last_q <= (raddr == AW'(DEPTH - 1));
            raddr     <= raddr + 1'b1;
            if (raddr == AW'(DEPTH - 1))
               rd_done <= 1'b1;
         end
      end
   end

   // Output register with a one-entry skid behind it; the output holds while
   // stalled and refills from the skid first, then from the RAM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
         skid_valid <= 1'b0;
      end else if ((state != DRAIN) || abort) begin
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!dout_valid || dout_ready) begin
         if (skid_valid) begin
            dout       <= skid_data;
            dout_last  <= skid_last;
            dout_valid <= 1'b1;
            if (rd_inflight) begin
               skid_data <= rd_data;
               skid_last <= rd_last_q;
            end else begin
               skid_valid <= 1'b0;
            end
         end else if (rd_inflight) begin
            dout       <= rd_data;
            dout_last  <= rd_last_q;
            dout_valid <= 1'b1;
         end else begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
         end
      end else if (rd_inflight) begin
         skid_data  <= rd_data;
         skid_last  <= rd_last_q;
         skid_valid <= 1'b1;
      end
   end

`ifdef FILT_CAPTURE_STATS_EN
   logic [DATA_W-1:0] mag;

   assign mag = DATA_W'(abs_sat(DATA_W_DEF'(y_q)));

   // Peak magnitude over the captured samples, starting fresh at the trigger
   // sample and holding once capture is over
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         peak <= '0;
      else if (trigger_fire)
         peak <= mag;
      else if ((state == CAPTURE) && !abort && (mag > peak))
         peak <= mag;
   end
`endif

   capture_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (waddr),
      .wr_data (y_q),
      .rd_en   (rd_en),
      .rd_addr (raddr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_filt_capture.sv
// Self-checking bench for filt_capture: random and directed sample streams
// compared against a behavioural capture model.
module tb_filt_capture;

   localparam int DATA_W = 18;
   localparam int DEPTH  = 256;
   localparam int LIMIT  = 3000;

   logic                     clk        = 1'b0;
   logic                     reset_n    = 1'b0;
   logic signed [DATA_W-1:0] y          = '0;
   logic                     arm        = 1'b0;
   logic                     abort      = 1'b0;
   logic                     trig_force = 1'b0;
   logic        [DATA_W-2:0] thresh     = '0;
   logic                     dout_ready = 1'b0;
   logic                     busy;
   logic signed [DATA_W-1:0] dout;
   logic                     dout_valid;
   logic                     dout_last;
`ifdef FILT_CAPTURE_STATS_EN
   logic        [DATA_W-1:0] peak;
   int                       exp_peak;
`endif

   int   total = 0;
   int   bad   = 0;

   int   exp_q[$];
   int   got_q[$];
   int   last_q[$];
   int   trig_j;
   int   first_valid_k;
   int   last_hs_k;
   int   stall_err;
   int   busy_low;
   logic busy_after_last;
   logic abort_valid_after;
   logic abort_busy_after;
   bit   timeout;

   filt_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .y          (y),
      .arm        (arm),
      .abort      (abort),
      .trig_force (trig_force),
      .thresh     (thresh),
      .busy       (busy),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last)
`ifdef FILT_CAPTURE_STATS_EN
      ,
      .peak       (peak)
`endif
   );

   always #5 clk = ~clk;

   function automatic int gen_sample(input int mode, input int k, input int th);
      case (mode)
         0:       return 100 * k;
         1:       return int'($urandom_range(262143)) - 131072;
         2:       return -131072;
         default: return (th <= 1) ? 0 : int'($urandom_range(2 * th - 2)) - (th - 1);
      endcase
   endfunction

   function automatic bit model_hit(input int v, input int th);
      return (v >= th) || (v <= -th);
   endfunction

   function automatic int abs_model(input int v);
      if (v == -131072) return 131071;
      return (v < 0) ? -v : v;
   endfunction

   // Drive one capture sequence from arm to the end of drain (or abort) and
   // record what came out alongside what the model expects.
   task automatic run_capture(input int th, input int mode, input int force_idx,
                              input int ready_pct, input int abort_after, input int arm_again_k);
      int   hs, abort_k, v;
      bit   found, done, prev_stall;
      logic signed [DATA_W-1:0] prev_dout;
      logic prev_last;
      exp_q.delete(); got_q.delete(); last_q.delete();
      trig_j = -1; first_valid_k = -1; last_hs_k = -1; stall_err = 0; busy_low = 0;
      busy_after_last = 1'bx; abort_valid_after = 1'bx; abort_busy_after = 1'bx; timeout = 0;
`ifdef FILT_CAPTURE_STATS_EN
      exp_peak = 0;
`endif
      hs = 0; abort_k = -1; found = 0; done = 0; prev_stall = 0;
      prev_dout = '0; prev_last = 1'b0;
      thresh = (DATA_W-1)'(th);
      for (int k = 0; k < LIMIT && !done; k++) begin
         @(posedge clk); #1;
         if (prev_stall && (dout_valid !== 1'b1 || dout !== prev_dout || dout_last !== prev_last))
            stall_err++;
         if (last_hs_k >= 0 && k == last_hs_k + 1) begin
            busy_after_last = busy;
            done = 1;
         end
         if (abort_k >= 0 && k == abort_k + 1) begin
            abort_valid_after = dout_valid;
            abort_busy_after  = busy;
            done = 1;
         end
         if (!done && k > 0 && busy !== 1'b1) busy_low++;
         if (dout_valid === 1'b1 && first_valid_k < 0) first_valid_k = k;
         if (!done) begin
            if (!found || k <= trig_j + DEPTH - 1) begin
               v = gen_sample(mode, k, th);
               if (!found && (model_hit(v, th) || k == force_idx)) begin
                  found  = 1;
                  trig_j = k;
               end
               if (found) begin
                  exp_q.push_back(v);
`ifdef FILT_CAPTURE_STATS_EN
                  if (abs_model(v) > exp_peak) exp_peak = abs_model(v);
`endif
               end
            end else begin
               v = gen_sample(1, k, th);
            end
            y          = v[DATA_W-1:0];
            arm        = (k == 0) || (k == arm_again_k);
            trig_force = (force_idx >= 0) && (k == force_idx + 1);
            abort      = (k == abort_k);
            dout_ready = (k == abort_k) ? 1'b0 : ($urandom_range(99) < ready_pct);
            prev_stall = dout_valid && !dout_ready && !abort;
            prev_dout  = dout;
            prev_last  = dout_last;
            if (dout_valid === 1'b1 && dout_ready) begin
               got_q.push_back(int'(dout));
               last_q.push_back(int'(dout_last));
               hs++;
               if (dout_last === 1'b1 || hs == DEPTH) last_hs_k = k;
               if (hs == abort_after) abort_k = k + 1;
            end
         end
      end
      if (!done) timeout = 1;
      arm = 0; trig_force = 0; abort = 0; dout_ready = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
      total++; if (dout !== '0) begin bad++; $display("[TB] FAIL rst_dout got=%0d want=0", dout); end
      total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b want=0", dout_valid); end
      total++; if (dout_last !== 1'b0) begin bad++; $display("[TB] FAIL rst_last got=%b want=0", dout_last); end
`ifdef FILT_CAPTURE_STATS_EN
      total++; if (peak !== '0) begin bad++; $display("[TB] FAIL rst_peak got=%0d want=0", peak); end
`endif
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_threshold_trigger();
      $display("[TB] threshold trigger on ramp");
      run_capture(1000, 0, -1, 100, -1, -1);
      total++; if (timeout) begin bad++; $display("[TB] FAIL thr_timeout got=1 want=0"); end
      total++; if (got_q.size() != DEPTH) begin bad++; $display("[TB] FAIL thr_count got=%0d want=%0d", got_q.size(), DEPTH); end
      total++; if (first_valid_k != 10 + DEPTH + 3) begin bad++; $display("[TB] FAIL thr_latency got=%0d want=%0d", first_valid_k, 10 + DEPTH + 3); end
      total++; if (last_hs_k != first_valid_k + DEPTH - 1) begin bad++; $display("[TB] FAIL thr_rate got=%0d want=%0d", last_hs_k, first_valid_k + DEPTH - 1); end
      total++; if (busy_after_last !== 1'b0) begin bad++; $display("[TB] FAIL thr_busy_fall got=%b want=0", busy_after_last); end
      total++; if (busy_low != 0) begin bad++; $display("[TB] FAIL thr_busy_low got=%0d want=0", busy_low); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] != exp_q[i]) begin bad++; $display("[TB] FAIL thr_data[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
         total++; if (last_q[i] != int'(i == DEPTH - 1)) begin bad++; $display("[TB] FAIL thr_last[%0d] got=%0d want=%0d", i, last_q[i], int'(i == DEPTH - 1)); end
      end
   endtask

   task automatic test_neg_fullscale();
      $display("[TB] negative full-scale trigger");
      run_capture(131071, 2, -1, 100, -1, -1);
      total++; if (got_q.size() != DEPTH) begin bad++; $display("[TB] FAIL neg_count got=%0d want=%0d", got_q.size(), DEPTH); end
      total++; if (first_valid_k != DEPTH + 3) begin bad++; $display("[TB] FAIL neg_latency got=%0d want=%0d", first_valid_k, DEPTH + 3); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] != exp_q[i]) begin bad++; $display("[TB] FAIL neg_data[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
      end
`ifdef FILT_CAPTURE_STATS_EN
      total++; if (int'(peak) != exp_peak) begin bad++; $display("[TB] FAIL neg_peak got=%0d want=%0d", peak, exp_peak); end
`endif
   endtask

   task automatic test_backpressure();
      $display("[TB] random backpressure, zero threshold");
      run_capture(0, 1, -1, 50, -1, -1);
      total++; if (timeout) begin bad++; $display("[TB] FAIL bp_timeout got=1 want=0"); end
      total++; if (got_q.size() != DEPTH) begin bad++; $display("[TB] FAIL bp_count got=%0d want=%0d", got_q.size(), DEPTH); end
      total++; if (stall_err != 0) begin bad++; $display("[TB] FAIL bp_stall got=%0d want=0", stall_err); end
      total++; if (first_valid_k != DEPTH + 3) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=%0d", first_valid_k, DEPTH + 3); end
      total++; if (busy_after_last !== 1'b0) begin bad++; $display("[TB] FAIL bp_busy_fall got=%b want=0", busy_after_last); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] != exp_q[i]) begin bad++; $display("[TB] FAIL bp_data[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
         total++; if (last_q[i] != int'(i == DEPTH - 1)) begin bad++; $display("[TB] FAIL bp_last[%0d] got=%0d want=%0d", i, last_q[i], int'(i == DEPTH - 1)); end
      end
`ifdef FILT_CAPTURE_STATS_EN
      total++; if (int'(peak) != exp_peak) begin bad++; $display("[TB] FAIL bp_peak got=%0d want=%0d", peak, exp_peak); end
`endif
   endtask

   task automatic test_force_ignore();
      int busy_seen;
      $display("[TB] forced trigger ignored in IDLE, re-arm ignored in CAPTURE");
      busy_seen = 0;
      thresh = (DATA_W-1)'(100);
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || dout_valid !== 1'b0) busy_seen++;
         trig_force = 1'b1;
         y = DATA_W'(gen_sample(1, k, 0));
      end
      @(posedge clk); #1;
      if (busy !== 1'b0 || dout_valid !== 1'b0) busy_seen++;
      trig_force = 1'b0;
      total++; if (busy_seen != 0) begin bad++; $display("[TB] FAIL idle_force got=%0d want=0", busy_seen); end
      run_capture(60000, 3, 7, 100, -1, 47);
      total++; if (got_q.size() != DEPTH) begin bad++; $display("[TB] FAIL frc_count got=%0d want=%0d", got_q.size(), DEPTH); end
      total++; if (first_valid_k != 7 + DEPTH + 3) begin bad++; $display("[TB] FAIL frc_latency got=%0d want=%0d", first_valid_k, 7 + DEPTH + 3); end
      total++; if (busy_low != 0) begin bad++; $display("[TB] FAIL frc_busy_low got=%0d want=0", busy_low); end
      total++; if (busy_after_last !== 1'b0) begin bad++; $display("[TB] FAIL frc_busy_fall got=%b want=0", busy_after_last); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] != exp_q[i]) begin bad++; $display("[TB] FAIL frc_data[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_abort_drain();
      $display("[TB] abort after 100 handshakes, then fresh capture");
      run_capture(50000, 3, 2, 100, 100, -1);
      total++; if (got_q.size() != 100) begin bad++; $display("[TB] FAIL abt_count got=%0d want=100", got_q.size()); end
      total++; if (abort_valid_after !== 1'b0) begin bad++; $display("[TB] FAIL abt_valid got=%b want=0", abort_valid_after); end
      total++; if (abort_busy_after !== 1'b0) begin bad++; $display("[TB] FAIL abt_busy got=%b want=0", abort_busy_after); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] != exp_q[i]) begin bad++; $display("[TB] FAIL abt_data[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
      end
      run_capture(50000, 3, 0, 70, -1, -1);
      total++; if (got_q.size() != DEPTH) begin bad++; $display("[TB] FAIL abt2_count got=%0d want=%0d", got_q.size(), DEPTH); end
      total++; if (stall_err != 0) begin bad++; $display("[TB] FAIL abt2_stall got=%0d want=0", stall_err); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] != exp_q[i]) begin bad++; $display("[TB] FAIL abt2_data[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_capture();
      int busy_seen;
      $display("[TB] asynchronous reset during capture");
      thresh = (DATA_W-1)'(131071);
      @(posedge clk); #1;
      arm = 1'b1;
      y   = DATA_W'(gen_sample(3, 0, 1000));
      @(posedge clk); #1;
      arm        = 1'b0;
      trig_force = 1'b1;
      @(posedge clk); #1;
      trig_force = 1'b0;
      repeat (49) @(posedge clk);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy got=%b want=1", busy); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL arst_busy got=%b want=0", busy); end
      total++; if (dout !== '0) begin bad++; $display("[TB] FAIL arst_dout got=%0d want=0", dout); end
      total++; if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_valid got=%b want=0", dout_valid); end
      total++; if (dout_last !== 1'b0) begin bad++; $display("[TB] FAIL arst_last got=%b want=0", dout_last); end
`ifdef FILT_CAPTURE_STATS_EN
      total++; if (peak !== '0) begin bad++; $display("[TB] FAIL arst_peak got=%0d want=0", peak); end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      thresh  = '0;
      busy_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (busy !== 1'b0) busy_seen++;
         y = DATA_W'(gen_sample(1, k, 0));
      end
      total++; if (busy_seen != 0) begin bad++; $display("[TB] FAIL post_rst_busy got=%0d want=0", busy_seen); end
      run_capture(20000, 3, 0, 100, -1, -1);
      total++; if (got_q.size() != DEPTH) begin bad++; $display("[TB] FAIL rst2_count got=%0d want=%0d", got_q.size(), DEPTH); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] != exp_q[i]) begin bad++; $display("[TB] FAIL rst2_data[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
      end
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_threshold_trigger();
      test_neg_fullscale();
      test_backpressure();
      test_force_ignore();
      test_abort_drain();
      test_reset_mid_capture();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
